// File: rtl/des_out_if.sv
// rtl/des_out_if.sv - handshake bundle between the DES final round, the output stage and the byte port
interface des_out_if;
    logic [31:0] l_in;
    logic [31:0] r_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;

    modport master (
        output l_in, r_in, in_valid, byte_ready,
        input  in_ready, byte_out, byte_valid, busy
    );

    modport slave (
        input  l_in, r_in, in_valid, byte_ready,
        output in_ready, byte_out, byte_valid, busy
    );
endinterface

// File: rtl/des_out_stage.sv
// rtl/des_out_stage.sv - DES final swap + IP^-1, byte serializer (optional DES_OUT_CHECKSUM_EN trailer byte)
module des_out_stage (
    input  logic        clk,
    input  logic        reset,
    des_out_if.slave    bus
);

`ifdef DES_OUT_CHECKSUM_EN
    localparam int            CW   = 4;
    localparam logic [CW-1:0] LAST = 4'd8;
`else
    localparam int            CW   = 3;
    localparam logic [CW-1:0] LAST = 3'd7;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     hold_q, hold_d;
    logic [63:0]     pre;
    logic [63:0]     blk;
    logic [7:0]      byte_sel;
    logic            last;

    // IP takes source bit ip_pos(k) to position k; the inverse scatters pre[k] back there.
    function automatic logic [5:0] ip_pos(input int k);
        int r;
        int c;
        int m;
        r = k / 8;
        c = k % 8;
        m = (r < 4) ? (57 + 2 * r - 8 * c) : (48 + 2 * r - 8 * c);
        return 6'(m);
    endfunction

    assign pre = {bus.r_in, bus.l_in};

    // Final swap already folded into pre; apply the inverse initial permutation.
    always_comb begin
        blk = '0;
        for (int k = 0; k < 64; k++) begin
            blk[ip_pos(k)] = pre[k];
        end
    end

`ifdef DES_OUT_CHECKSUM_EN
    logic [7:0] chk;

    // Trailer byte: XOR of the eight held data bytes.
    always_comb begin
        chk = '0;
        for (int b = 0; b < 8; b++) begin
            chk = chk ^ hold_q[8*b +: 8];
        end
    end

    assign byte_sel = count_q[3] ? chk : hold_q[{count_q[2:0], 3'b000} +: 8];
`else
    assign byte_sel = hold_q[{count_q, 3'b000} +: 8];
`endif

    assign last           = (count_q == LAST);
    assign bus.busy       = (state_q == SEND);
    assign bus.byte_valid = (state_q == SEND);
    assign bus.byte_out   = (state_q == SEND) ? byte_sel : 8'h00;
    assign bus.in_ready   = (state_q == IDLE) | ((state_q == SEND) & last & bus.byte_ready);

    // Next state: capture on accept, advance per byte handshake, chain blocks on the last byte.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_d  = blk;
                    count_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.byte_ready) begin
                    if (last) begin
                        count_d = '0;
                        if (bus.in_valid) begin
                            hold_d = blk;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, byte index and holding register; reset drops any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_des_out_stage.sv
// tb/tb_des_out_stage.sv - directed self-checking bench for des_out_stage
module tb_des_out_stage;

`ifdef DES_OUT_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    des_out_if bus ();

    des_out_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int ip_tbl [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) begin
            y[k] = x[ip_tbl[k] - 1];
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [63:0] pre);
        bus.r_in     = pre[63:32];
        bus.l_in     = pre[31:0];
        bus.in_valid = 1'b1;
    endtask

    // Called at a negedge with the stage idle; sends one block and collects its data bytes.
    task automatic xfer(input logic [63:0] pre, output logic [63:0] got, output int gaps);
        logic [7:0] x8;
        got  = '0;
        gaps = 0;
        load(pre);
        bus.byte_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.byte_valid) gaps++;
            got[8*i +: 8] = bus.byte_out;
            @(negedge clk);
        end
        if (NB == 9) begin
            x8 = '0;
            for (int b = 0; b < 8; b++) x8 = x8 ^ got[8*b +: 8];
            if (!bus.byte_valid) gaps++;
            check("xfer_checksum", bus.byte_out, x8);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] x;
        logic [63:0] x2;
        logic [63:0] got;
        logic [63:0] got2;
        logic [7:0]  eb;
        int          gaps;
        int          total_gaps;

        bus.l_in       = '0;
        bus.r_in       = '0;
        bus.in_valid   = 1'b0;
        bus.byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_byte_valid", bus.byte_valid, 0);
        check("rst_byte_out", bus.byte_out, 8'h00);
        check("rst_busy", bus.busy, 0);

        // Round trip
        x = 64'h0123456789ABCDEF;
        load(ip(x));
        bus.byte_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rt_busy", bus.busy, 1);
        for (int i = 0; i < NB; i++) begin
            eb = (i < 8) ? x[8*i +: 8] : 8'h00;
            check($sformatf("rt_byte%0d", i), bus.byte_out, eb);
            check($sformatf("rt_valid%0d", i), bus.byte_valid, 1);
            check($sformatf("rt_in_ready%0d", i), bus.in_ready, (i == NB - 1));
            @(negedge clk);
        end
        check("rt_idle_in_ready", bus.in_ready, 1);
        check("rt_idle_valid", bus.byte_valid, 0);
        check("rt_idle_busy", bus.busy, 0);

        // Single-bit walk
        total_gaps = 0;
        for (int k = 0; k < 64; k++) begin
            xfer(64'h1 << k, got, gaps);
            total_gaps += gaps;
            check($sformatf("walk%0d", k), got, 64'h1 << (ip_tbl[k] - 1));
        end
        check("walk_gaps", total_gaps, 0);

        // Backpressure at byte 3
        load(ip(x));
        bus.byte_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.byte_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold%0d", c), bus.byte_out, 8'h89);
            check($sformatf("bp_in_ready%0d", c), bus.in_ready, 0);
            check($sformatf("bp_valid%0d", c), bus.byte_valid, 1);
            @(negedge clk);
        end
        check("bp_still3", bus.byte_out, 8'h89);
        bus.byte_ready = 1'b1;
        @(negedge clk);
        check("bp_resume4", bus.byte_out, 8'h67);
        repeat (NB - 4) @(negedge clk);
        check("bp_idle", bus.in_ready, 1);

        // Back-to-back
        x  = 64'hDEADBEEF00C0FFEE;
        x2 = 64'h8877665544332211;
        load(ip(x));
        bus.byte_ready = 1'b1;
        @(negedge clk);
        load(ip(x2));
        gaps = 0;
        got  = '0;
        got2 = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            if (!bus.byte_valid) gaps++;
            if (i < 8) got[8*i +: 8] = bus.byte_out;
            else if (i >= NB && i < NB + 8) got2[8*(i-NB) +: 8] = bus.byte_out;
            if (i == NB - 1) check("b2b_accept", bus.in_ready, 1);
            if (i == NB) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_gaps", gaps, 0);
        check("b2b_blk1", got, x);
        check("b2b_blk2", got2, x2);
        check("b2b_idle", bus.byte_valid, 0);

        // Reset mid-block
        load(ip(64'hFEDCBA9876543210));
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_valid", bus.byte_valid, 0);
        check("mrst_in_ready", bus.in_ready, 1);
        check("mrst_byte_out", bus.byte_out, 8'h00);
        check("mrst_busy", bus.busy, 0);
        reset = 1'b0;
        x = 64'h0F1E2D3C4B5A6978;
        xfer(ip(x), got, gaps);
        check("mrst_new_blk", got, x);
        check("mrst_new_gaps", gaps, 0);
        check("mrst_new_idle", bus.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
